// File: rtl/uart_tx_engine.sv
// Bus-attached UART transmitter: register file, TX FIFO and a frame FSM with
// configurable data bits, parity and stop bits, runtime baud divisor and optional CTS gating.
module uart_tx_engine #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wen,
    input  logic                    ren,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] strobe,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    error,
    output logic                    request_stall,
    input  logic                    cts,
    output logic                    tx
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic [15:0] div_q;
    logic [1:0]  dbits_q;
    logic [1:0]  parity_q;
    logic        stop_q;
    logic        enable_q;
    logic        cts_en_q;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    state_e      state_q;
    logic [7:0]  shift_q;
    logic [15:0] baud_q;
    logic [15:0] reload_q;
    logic [2:0]  bit_idx_q;
    logic [1:0]  sh_dbits_q;
    logic        sh_par_en_q;
    logic        sh_stop_q;
    logic        par_bit_q;
    logic        stop_left_q;
    logic        tx_q;

    logic        upper_zero;
    logic        sel_txdata;
    logic        sel_status;
    logic        sel_config;
    logic        sel_ctrl;
    logic        mapped;
    logic        full;
    logic        empty;
    logic        busy;
    logic        bit_end;
    logic        stop_last;
    logic        start_go;
    logic        pop;
    logic        push;
    logic        flush;
    logic [7:0]  head;
    logic [15:0] div_eff;
    logic [7:0]  data_mask;
    logic        head_parity;
    logic        par_en;
    logic [31:0] rd32;
    logic        unused_bits;

    // Address decode: only the four word offsets with all upper bits clear are mapped.
    assign upper_zero = (addr[ADDR_WIDTH-1:4] == '0);
    assign sel_txdata = upper_zero && (addr[3:0] == 4'h0);
    assign sel_status = upper_zero && (addr[3:0] == 4'h4);
    assign sel_config = upper_zero && (addr[3:0] == 4'h8);
    assign sel_ctrl   = upper_zero && (addr[3:0] == 4'hC);
    assign mapped     = sel_txdata || sel_status || sel_config || sel_ctrl;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign busy  = (state_q != StIdle);

    assign bit_end   = (baud_q == '0);
    assign stop_last = (state_q == StStop) && bit_end && !stop_left_q;
    // A frame may begin from idle, or directly at the end of the last stop bit.
    assign start_go  = ((state_q == StIdle) || stop_last) && enable_q && !empty &&
                       (!cts_en_q || !cts);
    assign pop       = start_go;
    // A pop frees a slot at the same edge, so a full FIFO still accepts that push.
    assign push      = wen && sel_txdata && (!full || pop);
    assign flush     = wen && sel_ctrl && strobe[0] && wdata[2];

    assign head        = mem_q[rd_ptr_q];
    assign div_eff     = (div_q == '0) ? 16'd1 : div_q;
    assign data_mask   = 8'hFF >> (2'd3 - dbits_q);
    assign head_parity = (^(head & data_mask)) ^ (parity_q == 2'd2);
    assign par_en      = (parity_q == 2'd1) || (parity_q == 2'd2);

    assign error = ((wen || ren) && !mapped) || (wen && sel_status) ||
                   (ren && sel_txdata) || (wen && sel_txdata && full && !pop);

    always_comb begin
        rd32 = '0;
        if (ren) begin
            if (sel_status) begin
                rd32 = {16'h0, 8'(count_q), 5'h0, busy, empty, full};
            end else if (sel_config) begin
                rd32 = {10'h0, stop_q, parity_q, 1'b0, dbits_q, div_q};
            end else if (sel_ctrl) begin
                rd32 = {30'h0, cts_en_q, enable_q};
            end
        end
        rdata = '0;
        rdata[31:0] = rd32;
    end

    assign request_stall = 1'b0;
    assign tx            = tx_q;
    assign unused_bits   = ^{wdata[DATA_WIDTH-1:22], wdata[18], strobe[DATA_WIDTH/8-1:3]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q    <= DEFAULT_DIV;
            dbits_q  <= 2'd3;
            parity_q <= 2'd0;
            stop_q   <= 1'b0;
            enable_q <= 1'b0;
            cts_en_q <= 1'b0;
        end else begin
            if (wen && sel_config) begin
                if (strobe[0]) div_q[7:0]  <= wdata[7:0];
                if (strobe[1]) div_q[15:8] <= wdata[15:8];
                if (strobe[2]) begin
                    dbits_q  <= wdata[17:16];
                    parity_q <= wdata[20:19];
                    stop_q   <= wdata[21];
                end
            end
            if (wen && sel_ctrl && strobe[0]) begin
                enable_q <= wdata[0];
                cts_en_q <= wdata[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Frame FSM; divisor and format are captured into shadows at frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            tx_q        <= 1'b1;
            shift_q     <= '0;
            baud_q      <= '0;
            reload_q    <= '0;
            bit_idx_q   <= '0;
            sh_dbits_q  <= 2'd3;
            sh_par_en_q <= 1'b0;
            sh_stop_q   <= 1'b0;
            par_bit_q   <= 1'b0;
            stop_left_q <= 1'b0;
        end else if (start_go) begin
            state_q     <= StStart;
            tx_q        <= 1'b0;
            shift_q     <= head;
            baud_q      <= div_eff - 16'd1;
            reload_q    <= div_eff - 16'd1;
            sh_dbits_q  <= dbits_q;
            sh_par_en_q <= par_en;
            sh_stop_q   <= stop_q;
            par_bit_q   <= head_parity;
        end else if (state_q != StIdle) begin
            if (!bit_end) begin
                baud_q <= baud_q - 16'd1;
            end else begin
                baud_q <= reload_q;
                case (state_q)
                    StStart: begin
                        state_q   <= StData;
                        tx_q      <= shift_q[0];
                        bit_idx_q <= '0;
                    end
                    StData: begin
                        if (bit_idx_q == ({1'b0, sh_dbits_q} + 3'd4)) begin
                            if (sh_par_en_q) begin
                                state_q <= StParity;
                                tx_q    <= par_bit_q;
                            end else begin
                                state_q     <= StStop;
                                tx_q        <= 1'b1;
                                stop_left_q <= sh_stop_q;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end
                    StParity: begin
                        state_q     <= StStop;
                        tx_q        <= 1'b1;
                        stop_left_q <= sh_stop_q;
                    end
                    StStop: begin
                        if (stop_left_q) begin
                            stop_left_q <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: directed frames pinned by literals, then
// randomized bus traffic checked every cycle against a frame-timeline model.
module tb_uart_tx_engine;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wen = 1'b0;
    logic        ren = 1'b0;
    logic        cts = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  strobe = '0;
    logic [31:0] rdata;
    logic        error;
    logic        request_stall;
    logic        tx;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_engine #(
        .FIFO_DEPTH (DEPTH),
        .DEFAULT_DIV(16'd868),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wen          (wen),
        .ren          (ren),
        .addr         (addr),
        .wdata        (wdata),
        .strobe       (strobe),
        .rdata        (rdata),
        .error        (error),
        .request_stall(request_stall),
        .cts          (cts),
        .tx           (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: FIFO as a queue, live config, and the current frame as a list of bit values
    // with a period; tx is the bit at index (elapsed cycles / period).
    logic [7:0]  m_q[$];
    logic [15:0] m_div;
    logic [1:0]  m_dbits;
    logic [1:0]  m_par;
    logic        m_stop;
    logic        m_en;
    logic        m_ctsen;
    bit          m_active;
    int          m_t;
    int          m_len;
    int          m_period;
    int          m_nbits;
    int          m_bits[12];

    task automatic m_reset();
        m_q.delete();
        m_div    = 16'd868;
        m_dbits  = 2'd3;
        m_par    = 2'd0;
        m_stop   = 1'b0;
        m_en     = 1'b0;
        m_ctsen  = 1'b0;
        m_active = 1'b0;
        m_t      = 0;
        m_len    = 0;
        m_period = 1;
        m_nbits  = 0;
    endtask

    function automatic bit m_ending();
        return m_active && (m_t + 1 == m_len);
    endfunction

    function automatic bit m_can_start();
        return (!m_active || m_ending()) && m_en && (m_q.size() > 0) && (!m_ctsen || !cts);
    endfunction

    task automatic m_start_frame(input logic [7:0] b);
        int ones;
        int nb;
        ones = 0;
        nb = int'(m_dbits) + 5;
        m_period = (m_div == 16'd0) ? 1 : int'(m_div);
        m_nbits = 0;
        m_bits[m_nbits] = 0;
        m_nbits++;
        for (int i = 0; i < nb; i++) begin
            m_bits[m_nbits] = int'(b[i]);
            m_nbits++;
            ones += int'(b[i]);
        end
        if (m_par == 2'd1) begin
            m_bits[m_nbits] = ones % 2;
            m_nbits++;
        end else if (m_par == 2'd2) begin
            m_bits[m_nbits] = 1 - (ones % 2);
            m_nbits++;
        end
        m_bits[m_nbits] = 1;
        m_nbits++;
        if (m_stop) begin
            m_bits[m_nbits] = 1;
            m_nbits++;
        end
        m_len = m_nbits * m_period;
        m_t = 0;
        m_active = 1'b1;
    endtask

    task automatic m_step();
        bit go;
        bit ending;
        bit full0;
        go = m_can_start();
        ending = m_ending();
        full0 = (m_q.size() == DEPTH);
        if (go) m_start_frame(m_q.pop_front());
        else if (ending) m_active = 1'b0;
        else if (m_active) m_t++;
        if (wen && addr == 32'h0 && (!full0 || go)) m_q.push_back(wdata[7:0]);
        if (wen && addr == 32'hC && strobe[0] && wdata[2]) m_q.delete();
        if (wen && addr == 32'h8) begin
            if (strobe[0]) m_div[7:0] = wdata[7:0];
            if (strobe[1]) m_div[15:8] = wdata[15:8];
            if (strobe[2]) begin
                m_dbits = wdata[17:16];
                m_par   = wdata[20:19];
                m_stop  = wdata[21];
            end
        end
        if (wen && addr == 32'hC && strobe[0]) begin
            m_en    = wdata[0];
            m_ctsen = wdata[1];
        end
    endtask

    function automatic logic m_tx();
        if (m_active) return (m_bits[m_t / m_period] != 0);
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a)
            32'h4: return {16'h0, 8'(m_q.size()), 5'h0, m_active, (m_q.size() == 0),
                           (m_q.size() == DEPTH)};
            32'h8: return {10'h0, m_stop, m_par, 1'b0, m_dbits, m_div};
            32'hC: return {30'h0, m_ctsen, m_en};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_error();
        bit mapped;
        mapped = (addr == 32'h0) || (addr == 32'h4) || (addr == 32'h8) || (addr == 32'hC);
        if ((wen || ren) && !mapped) return 1'b1;
        if (wen && addr == 32'h4) return 1'b1;
        if (ren && addr == 32'h0) return 1'b1;
        if (wen && addr == 32'h0 && m_q.size() == DEPTH && !m_can_start()) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) m_reset();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("tx", 32'(tx), 32'(m_tx()));
            check("request_stall", 32'(request_stall), 32'h0);
            check("rdata", rdata, ren ? m_read(addr) : 32'h0);
            check("error", 32'(error), 32'(m_error()));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic e);
        wen = 1'b1;
        addr = a;
        wdata = d;
        strobe = s;
        @(negedge clk);
        e = error;
        cyc();
        wen = 1'b0;
        strobe = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic e);
        ren = 1'b1;
        addr = a;
        @(negedge clk);
        d = rdata;
        e = error;
        cyc();
        ren = 1'b0;
    endtask

    initial begin
        logic        e;
        logic [31:0] d;
        logic [9:0]  got10;
        logic [9:0]  exp10;
        logic [10:0] got11;
        logic [10:0] exp11;
        logic        all_high;
        logic [31:0] waddrs[5];
        logic [31:0] raddrs[7];

        waddrs = '{32'h4, 32'h10, 32'h2, 32'h100C, 32'h0};
        raddrs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h6, 32'h2004};

        repeat (3) cyc();
        reset = 1'b0;
        cyc();

        // Reset state
        rd(32'h4, d, e);
        check("reset STATUS", d, 32'h0000_0002);
        check("reset STATUS error", 32'(e), 32'h0);
        check("reset tx", 32'(tx), 32'h1);
        rd(32'h8, d, e);
        check("reset CONFIG", d, 32'h0003_0364);
        rd(32'hC, d, e);
        check("reset CTRL", d, 32'h0);

        // 8N1 at div=4, byte 0xA5
        wr(32'h8, 32'h0003_0004, 4'hF, e);
        wr(32'hC, 32'h1, 4'h1, e);
        wr(32'h0, 32'hA5, 4'h1, e);
        repeat (3) cyc();
        for (int k = 0; k < 10; k++) begin
            got10[k] = tx;
            repeat (4) cyc();
        end
        exp10 = 10'b1101001010;
        check("8N1 0xA5 bits", 32'(got10), 32'(exp10));
        rd(32'h4, d, e);
        check("8N1 idle after frame", d, 32'h0000_0002);

        // 7E2 at div=2, byte 0x43
        wr(32'h8, 32'h002A_0002, 4'hF, e);
        wr(32'h0, 32'h43, 4'h1, e);
        repeat (2) cyc();
        for (int k = 0; k < 11; k++) begin
            got11[k] = tx;
            repeat (2) cyc();
        end
        exp11 = 11'b11110000110;
        check("7E2 0x43 bits", 32'(got11), 32'(exp11));
        rd(32'h4, d, e);
        check("7E2 idle after frame", d, 32'h0000_0002);

        // FIFO full / overflow / flush with transmitter disabled
        wr(32'hC, 32'h0, 4'h1, e);
        for (int k = 0; k < 5; k++) begin
            wr(32'h0, 32'(8'h10 + k), 4'h1, e);
            check("fill error", 32'(e), (k == 4) ? 32'h1 : 32'h0);
        end
        rd(32'h4, d, e);
        check("full STATUS", d, 32'h0000_0401);
        wr(32'hC, 32'h4, 4'h1, e);
        rd(32'h4, d, e);
        check("flushed STATUS", d, 32'h0000_0002);

        // CTS gating
        cts = 1'b1;
        wr(32'hC, 32'h3, 4'h1, e);
        wr(32'h0, 32'h5A, 4'h1, e);
        all_high = 1'b1;
        for (int k = 0; k < 100; k++) begin
            all_high &= tx;
            cyc();
        end
        check("cts hold idle", 32'(all_high), 32'h1);
        cts = 1'b0;
        cyc();
        check("start after cts", 32'(tx), 32'h0);
        repeat (3) cyc();
        cts = 1'b1;
        repeat (30) cyc();
        rd(32'h4, d, e);
        check("cts frame done", d, 32'h0000_0002);
        wr(32'hC, 32'h0, 4'h1, e);
        cts = 1'b0;

        // Unmapped read, then reset mid-DATA
        rd(32'h10, d, e);
        check("unmapped rdata", d, 32'h0);
        check("unmapped error", 32'(e), 32'h1);
        wr(32'h8, 32'h0003_0004, 4'hF, e);
        wr(32'hC, 32'h1, 4'h1, e);
        wr(32'h0, 32'h00, 4'h1, e);
        repeat (10) cyc();
        check("pre-reset data bit", 32'(tx), 32'h0);
        reset = 1'b1;
        #1;
        check("async reset tx", 32'(tx), 32'h1);
        repeat (2) cyc();
        reset = 1'b0;
        rd(32'h4, d, e);
        check("post-reset STATUS", d, 32'h0000_0002);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int op;
            logic [31:0] cfg;
            op = $urandom_range(0, 99);
            if (op < 30) begin
                wr(32'h0, $urandom, 4'hF, e);
            end else if (op < 38) begin
                cfg = 32'($urandom_range(0, 5)) | (32'($urandom_range(0, 3)) << 16) |
                      (32'($urandom_range(0, 3)) << 19) | (32'($urandom_range(0, 1)) << 21) |
                      ($urandom & 32'hFFC0_0000);
                wr(32'h8, cfg, 4'($urandom), e);
            end else if (op < 46) begin
                wr(32'hC, {29'h0, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                           ($urandom_range(0, 3) != 0)}, 4'($urandom), e);
            end else if (op < 62) begin
                rd(raddrs[$urandom_range(0, 6)], d, e);
            end else if (op < 70) begin
                wr(waddrs[$urandom_range(0, 4)], $urandom, 4'($urandom), e);
            end else if (op < 78) begin
                cts = 1'($urandom_range(0, 1));
                cyc();
            end else begin
                repeat ($urandom_range(1, 8)) cyc();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
